mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   MEM-stage load/store engine between the EX->MEM pipeline register and MEMtoWB.
//   Decodes the memory op, checks address legality, drives the data bus with a req/ack
//   handshake (stalling the pipeline while waiting), and produces the sign/zero-extended
//   load word for MEM_memRD and the exception code for the CP0 path.
// PARAMETERS
//   DM_END      32'h0000_2FFF  last byte of data memory; DM range is 0..DM_END
//   TC0_BASE    32'h0000_7F00  timer0 base; 3 words, offsets 0/4/8
//   TC1_BASE    32'h0000_7F10  timer1 base; 3 words, offsets 0/4/8
//   IG_BASE     32'h0000_7F20  interrupt generator; 1 word
//   TIMEOUT     15             WAIT cycles without bus_ack before bus-error abort
// PORTS
//   clk         in   1   clock
//   reset       in   1   synchronous, active-high
//   Req         in   1   exception/interrupt flush; kills any in-flight access
//   mem_valid   in   1   MEM stage holds a live instruction
//   mem_op      in   4   0 none,1 LW,2 LH,3 LHU,4 LB,5 LBU,6 SW,7 SH,8 SB
//   mem_addr    in   32  effective address from ALU
//   mem_ovf     in   1   ALU overflow while computing mem_addr
//   mem_wdata   in   32  store data (forwarded rt)
//   bus_req     out  1   bus transaction request
//   bus_we      out  1   1 = store
//   bus_addr    out  32  word-aligned address ({mem_addr[31:2],2'b00})
//   bus_byteen  out  4   byte enables (stores); 4'b0000 on loads
//   bus_wdata   out  32  store data shifted into lane(s)
//   bus_ack     in   1   target accepted / returned data this cycle
//   bus_rdata   in   32  read data, valid with bus_ack
//   mem_rdata   out  32  extended load result -> MEM_memRD
//   mem_exc     out  5   0 none, 4 AdEL, 5 AdES, 7 DBE (bus timeout)
//   mem_stall   out  1   freeze IF..MEM while 1
// BEHAVIOUR
//   Reset: state IDLE; bus_req 0, bus_we 0, bus_byteen 0, bus_addr 0, bus_wdata 0,
//     mem_rdata 0, mem_exc 0, mem_stall 0, timeout counter 0.
//   Legality (combinational, only when mem_valid & op!=0):
//     AdEL (loads)/AdES (stores): misaligned (word addr[1:0]!=0, half addr[0]!=0);
//     mem_ovf; address outside DM/TC0/TC1/IG; half/byte access to TC0/TC1/IG;
//     store to timer offset 8 (COUNT, read-only).
//   Illegal access: no bus activity, mem_stall 0, mem_exc valid same cycle.
//   FSM IDLE -> WAIT -> DONE -> IDLE:
//     IDLE: legal op -> bus_req/bus_we/bus_addr/bus_byteen/bus_wdata registered,
//       go WAIT; mem_stall=1 combinationally this cycle.
//     WAIT: bus outputs held stable, mem_stall=1, counter increments each cycle.
//       bus_ack -> capture extended bus_rdata into mem_rdata, drop bus_req, go DONE.
//       counter==TIMEOUT without ack -> drop bus_req, mem_exc=7, go DONE.
//     DONE: mem_stall=0, mem_rdata/mem_exc stable for the pipeline to advance;
//       next cycle IDLE (new instruction evaluated there). Min load latency 2 cycles.
//   Extension: LH/LB sign-extend, LHU/LBU zero-extend the lane by addr[1:0];
//     LW passes through. Stores: mem_rdata unchanged.
//   Byte enables: SW 4'b1111; SH 4'b0011/4'b1100 by addr[1]; SB 4'b0001<<addr[1:0].
//   bus_wdata: SH/SB replicate low half/byte into all lanes.
//   Req or reset in any state: next cycle IDLE, bus_req 0, counter 0, mem_exc 0;
//     an ack arriving in that same cycle is discarded.
//   bus_ack while IDLE/DONE ignored. Counter saturates; never wraps.
// TESTING
//   LW 0x0000_0010, ack after 3 WAIT cycles, rdata 0xDEADBEEF -> stall 4 cycles,
//     mem_rdata 0xDEADBEEF in DONE, mem_exc 0.
//   LB 0x0000_0013, rdata 0x80FF_FF7F -> mem_rdata 0xFFFFFF80; LBU -> 0x00000080.
//   SH 0x0000_0102, wdata 0x0000_1234 -> bus_byteen 4'b1100, bus_wdata 0x12341234,
//     bus_addr 0x0000_0100, bus_we 1.
//   LW 0x0000_0006 -> mem_exc 4, no bus_req, stall 0; SW 0x7F08 -> mem_exc 5;
//     LH 0x7F00 -> mem_exc 4; LW 0x0000_3000 -> mem_exc 4.
//   LW 0x7F04, no ack -> after TIMEOUT(15) WAIT cycles mem_exc 7, stall drops.
//   Req asserted 2 cycles into WAIT with ack same cycle -> IDLE, bus_req 0, rdata dropped.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data bus bundle between the MEM-stage access unit and memory/peripheral targets
// Purpose: groups the req/ack data bus so the access unit and its targets share one port.
// Signals:
//   bus_req     request, held until ack or abort
//   bus_we      1 = store
//   bus_addr    word-aligned address
//   bus_byteen  store byte enables (0 on loads)
//   bus_wdata   store data replicated into lanes
//   bus_ack     target accepted / returned data this cycle
//   bus_rdata   read data, valid with bus_ack
// Modports: master (access unit), slave (memory/peripheral side).
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store engine with legality checks, bus handshake and timeout
// Purpose: decodes the memory op, rejects illegal addresses with AdEL/AdES, runs one
//   req/ack bus transaction per legal op while stalling the pipeline, extends load data
//   and reports a bus-error code when the target never answers.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   Req              exception/interrupt flush, kills any in-flight access
//   mem_valid        live instruction in MEM
//   mem_op           0 none,1 LW,2 LH,3 LHU,4 LB,5 LBU,6 SW,7 SH,8 SB
//   mem_addr         effective address; mem_ovf flags ALU overflow on it
//   mem_wdata        store data
//   bus              data bus (master modport)
//   mem_rdata        extended load result
//   mem_exc          0 none, 4 AdEL, 5 AdES, 7 DBE
//   mem_stall        pipeline freeze
module mem_access_unit #(
  parameter logic [31:0] DM_END   = 32'h0000_2FFF,
  parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
  parameter logic [31:0] IG_BASE  = 32'h0000_7F20,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        mem_valid,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic        mem_ovf,
  input  logic [31:0] mem_wdata,
  mem_access_unit_if.master bus,
  output logic [31:0] mem_rdata,
  output logic [4:0]  mem_exc,
  output logic        mem_stall
);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  localparam logic [4:0] TIMEOUT_CNT = 5'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_n;

  // Decode / legality of the op currently presented by the pipeline
  logic        is_word, is_half, is_load, is_store, live;
  logic        misaligned, in_dm, in_tc, in_ig, store_count, illegal;
  logic [4:0]  addr_exc;
  logic [3:0]  byteen_n;
  logic [31:0] wdata_n;

  // Registered transaction context
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  byteen_q;
  logic [3:0]  op_q;
  logic [1:0]  lane_q;
  logic [4:0]  cnt, cnt_inc;
  logic [4:0]  exc_q;

  // FSM-derived strobes
  logic        start, ack_hit, timeout_hit;

  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic [31:0] rd_ext;

  assign bus.bus_req    = req_q;
  assign bus.bus_we     = we_q;
  assign bus.bus_addr   = addr_q;
  assign bus.bus_byteen = byteen_q;
  assign bus.bus_wdata  = wdata_q;

  always_comb begin
    is_word  = (mem_op == OP_LW) || (mem_op == OP_SW);
    is_half  = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
    is_load  = (mem_op >= OP_LW) && (mem_op <= OP_LBU);
    is_store = (mem_op >= OP_SW) && (mem_op <= OP_SB);
    // A flush in the same cycle wins over starting a new access
    live     = mem_valid && (is_load || is_store) && !Req;

    misaligned  = is_word ? (mem_addr[1:0] != 2'b00) : (is_half && mem_addr[0]);
    in_dm       = (mem_addr <= DM_END);
    in_tc       = ((mem_addr >= TC0_BASE) && (mem_addr <= TC0_BASE + 32'd11)) ||
                  ((mem_addr >= TC1_BASE) && (mem_addr <= TC1_BASE + 32'd11));
    in_ig       = (mem_addr >= IG_BASE) && (mem_addr <= IG_BASE + 32'd3);
    // Timer COUNT register is read-only
    store_count = is_store && ((mem_addr == TC0_BASE + 32'd8) || (mem_addr == TC1_BASE + 32'd8));
    illegal     = misaligned || mem_ovf || !(in_dm || in_tc || in_ig) ||
                  ((in_tc || in_ig) && !is_word) || store_count;
    addr_exc    = is_store ? EXC_ADES : EXC_ADEL;

    byteen_n = 4'b0000;
    wdata_n  = mem_wdata;
    case (mem_op)
      OP_SW: byteen_n = 4'b1111;
      OP_SH: begin
        byteen_n = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n  = {2{mem_wdata[15:0]}};
      end
      OP_SB: begin
        byteen_n = 4'b0001 << mem_addr[1:0];
        wdata_n  = {4{mem_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the captured address bits; the pipeline inputs may move once DONE is reached
  always_comb begin
    rd_half = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    rd_byte = bus.bus_rdata[{lane_q, 3'b000} +: 8];
    case (op_q)
      OP_LH:   rd_ext = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  rd_ext = {16'h0000, rd_half};
      OP_LB:   rd_ext = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  rd_ext = {24'h000000, rd_byte};
      default: rd_ext = bus.bus_rdata;
    endcase
  end

  always_comb begin
    cnt_inc = (cnt == 5'h1F) ? cnt : cnt + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    start       = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    mem_stall   = 1'b0;
    mem_exc     = exc_q;
    case (state)
      IDLE: begin
        mem_exc = EXC_NONE;
        if (live && illegal) begin
          mem_exc = addr_exc;
        end else if (live) begin
          start     = 1'b1;
          mem_stall = 1'b1;
          state_n   = WAIT;
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (bus.bus_ack) begin
          ack_hit = 1'b1;
          state_n = DONE;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          timeout_hit = 1'b1;
          state_n     = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (Req) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      byteen_q  <= 4'd0;
      wdata_q   <= 32'd0;
      op_q      <= 4'd0;
      lane_q    <= 2'd0;
      cnt       <= 5'd0;
      exc_q     <= EXC_NONE;
      mem_rdata <= 32'd0;
    end else if (Req) begin
      // Flush: abandon the access; a same-cycle ack is dropped
      req_q <= 1'b0;
      cnt   <= 5'd0;
      exc_q <= EXC_NONE;
    end else begin
      if (start) begin
        req_q    <= 1'b1;
        we_q     <= is_store;
        addr_q   <= {mem_addr[31:2], 2'b00};
        byteen_q <= byteen_n;
        wdata_q  <= wdata_n;
        op_q     <= mem_op;
        lane_q   <= mem_addr[1:0];
        cnt      <= 5'd0;
        exc_q    <= EXC_NONE;
      end
      if (state == WAIT) cnt <= cnt_inc;
      if (ack_hit) begin
        req_q <= 1'b0;
        if (op_q <= OP_LBU) mem_rdata <= rd_ext;
      end
      if (timeout_hit) begin
        req_q <= 1'b0;
        exc_q <= EXC_DBE;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset, Req, mem_valid, mem_ovf;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [4:0]  mem_exc;
  logic        mem_stall;

  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk       (clk),
    .reset     (reset),
    .Req       (Req),
    .mem_valid (mem_valid),
    .mem_op    (mem_op),
    .mem_addr  (mem_addr),
    .mem_ovf   (mem_ovf),
    .mem_wdata (mem_wdata),
    .bus       (bus),
    .mem_rdata (mem_rdata),
    .mem_exc   (mem_exc),
    .mem_stall (mem_stall)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] ref_rdata = 32'd0;
  logic [31:0] cap_addr, cap_wd;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic [4:0]  obs_issue_exc, obs_done_exc;
  int          obs_stalls;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd6) return 4;
    if (op == 4'd2 || op == 4'd3 || op == 4'd7) return 2;
    return 1;
  endfunction

  function automatic logic [4:0] ref_exc(input logic [3:0] op, input logic [31:0] addr, input logic ovf);
    longint unsigned a, last;
    int sz;
    bit st, tmr, ig, ok;
    sz   = size_of(op);
    st   = (op >= 4'd6);
    a    = addr;
    last = a + longint'(sz) - 1;
    tmr  = (a >= 'h7F00 && last <= 'h7F0B) || (a >= 'h7F10 && last <= 'h7F1B);
    ig   = (a >= 'h7F20 && last <= 'h7F23);
    ok   = (a % sz == 0) && !ovf && (last <= 'h2FFF || ((tmr || ig) && sz == 4)) &&
           !(st && tmr && (a % 16 == 8));
    if (ok) return 5'd0;
    return st ? 5'd5 : 5'd4;
  endfunction

  function automatic logic [31:0] ref_ext(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * addr[1:0]);
    case (op)
      4'd2: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v + 32'hFFFF_0000; end
      4'd3: v = v & 32'hFFFF;
      4'd4: begin v = v & 32'hFF; if (v >= 32'h80) v = v + 32'hFFFF_FF00; end
      4'd5: v = v & 32'hFF;
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [3:0] op, input logic [31:0] addr);
    int sz;
    sz = size_of(op);
    if (op < 4'd6) return 4'd0;
    if (sz == 4) return 4'hF;
    return 4'(((1 << sz) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] ref_wd(input logic [3:0] op, input logic [31:0] wd);
    int sz;
    sz = size_of(op);
    if (sz == 4) return wd;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return (wd & 32'hFF) * 32'h0101_0101;
  endfunction

  // One pipeline access; ack_at = WAIT cycle (1-based) in which the target acks, 0 = never
  task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic ovf,
                        input logic [31:0] wd, input int ack_at, input logic [31:0] rd);
    logic [4:0] e;
    int  stalls;
    bit  finished;
    e = ref_exc(op, addr, ovf);
    @(negedge clk);
    mem_valid = 1'b1; mem_op = op; mem_addr = addr; mem_ovf = ovf; mem_wdata = wd;
    bus.bus_ack = 1'b1; bus.bus_rdata = $urandom;   // stray ack in IDLE must be ignored
    #1;
    obs_issue_exc = mem_exc;
    chk("issue_exc", 32'(mem_exc), 32'(e));
    if (e != 5'd0) begin
      chk("illegal_stall", 32'(mem_stall), 32'd0);
      @(negedge clk);
      mem_valid = 1'b0; bus.bus_ack = 1'b0;
      #1;
      chk("illegal_noreq", 32'(bus.bus_req), 32'd0);
      chk("illegal_rdata", mem_rdata, ref_rdata);
      return;
    end
    chk("issue_stall", 32'(mem_stall), 32'd1);
    stalls   = 1;
    finished = 0;
    for (int c = 1; c <= 40 && !finished; c++) begin
      @(negedge clk);
      bus.bus_ack   = (c == ack_at);
      bus.bus_rdata = (c == ack_at) ? rd : $urandom;
      #1;
      if (c == 1) begin
        cap_addr = bus.bus_addr; cap_be = bus.bus_byteen; cap_wd = bus.bus_wdata; cap_we = bus.bus_we;
        chk("wait_req", 32'(bus.bus_req), 32'd1);
        chk("wait_we", 32'(bus.bus_we), 32'(op >= 4'd6));
        chk("wait_addr", bus.bus_addr, addr & 32'hFFFF_FFFC);
        chk("wait_be", 32'(bus.bus_byteen), 32'(ref_be(op, addr)));
        if (op >= 4'd6) chk("wait_wdata", bus.bus_wdata, ref_wd(op, wd));
      end
      if (mem_stall) stalls++;
      else finished = 1;
    end
    if (ack_at > 0 && op <= 4'd5) ref_rdata = ref_ext(op, addr, rd);
    obs_stalls   = stalls;
    obs_done_exc = mem_exc;
    chk("stall_cycles", 32'(stalls), 32'((ack_at > 0) ? ack_at + 1 : TO + 1));
    chk("done_exc", 32'(mem_exc), (ack_at > 0) ? 32'd0 : 32'd7);
    chk("done_rdata", mem_rdata, ref_rdata);
    chk("done_req", 32'(bus.bus_req), 32'd0);
    // stray ack in DONE must not disturb the result
    bus.bus_ack = 1'b1; bus.bus_rdata = $urandom; mem_valid = 1'b0;
    @(negedge clk);
    bus.bus_ack = 1'b0;
    #1;
    chk("idle_rdata", mem_rdata, ref_rdata);
    chk("idle_stall", 32'(mem_stall), 32'd0);
    chk("idle_exc", 32'(mem_exc), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  op;
    int          ack;

    reset = 1'b1; Req = 1'b0; mem_valid = 1'b0; mem_op = 4'd0; mem_addr = 32'd0;
    mem_ovf = 1'b0; mem_wdata = 32'd0; bus.bus_ack = 1'b0; bus.bus_rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_req", 32'(bus.bus_req), 32'd0);
    chk("rst_we", 32'(bus.bus_we), 32'd0);
    chk("rst_addr", bus.bus_addr, 32'd0);
    chk("rst_be", 32'(bus.bus_byteen), 32'd0);
    chk("rst_wdata", bus.bus_wdata, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_exc", 32'(mem_exc), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);

    access(4'd1, 32'h0000_0010, 1'b0, 32'd0, 3, 32'hDEAD_BEEF);
    chk("lw_const_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("lw_const_stalls", 32'(obs_stalls), 32'd4);

    access(4'd4, 32'h0000_0013, 1'b0, 32'd0, 1, 32'h80FF_FF7F);
    chk("lb_const", mem_rdata, 32'hFFFF_FF80);
    access(4'd5, 32'h0000_0013, 1'b0, 32'd0, 2, 32'h80FF_FF7F);
    chk("lbu_const", mem_rdata, 32'h0000_0080);

    access(4'd7, 32'h0000_0102, 1'b0, 32'h0000_1234, 2, 32'h0);
    chk("sh_be", 32'(cap_be), 32'b1100);
    chk("sh_wdata", cap_wd, 32'h1234_1234);
    chk("sh_addr", cap_addr, 32'h0000_0100);
    chk("sh_we", 32'(cap_we), 32'd1);
    chk("sh_rdata_kept", mem_rdata, 32'h0000_0080);

    access(4'd1, 32'h0000_0006, 1'b0, 32'd0, 1, 32'd0);
    chk("lw_mis_const", 32'(obs_issue_exc), 32'd4);
    access(4'd6, 32'h0000_7F08, 1'b0, 32'd0, 1, 32'd0);
    chk("sw_count_const", 32'(obs_issue_exc), 32'd5);
    access(4'd2, 32'h0000_7F00, 1'b0, 32'd0, 1, 32'd0);
    chk("lh_timer_const", 32'(obs_issue_exc), 32'd4);
    access(4'd1, 32'h0000_3000, 1'b0, 32'd0, 1, 32'd0);
    chk("lw_outside_const", 32'(obs_issue_exc), 32'd4);
    access(4'd1, 32'h0000_2FFC, 1'b0, 32'd0, 1, 32'h0BAD_F00D);
    chk("lw_dm_last", mem_rdata, 32'h0BAD_F00D);

    access(4'd1, 32'h0000_7F04, 1'b0, 32'd0, 0, 32'd0);
    chk("timeout_exc_const", 32'(obs_done_exc), 32'd7);
    chk("timeout_stall_const", 32'(obs_stalls), 32'd16);

    // Flush two cycles into WAIT with a simultaneous ack: data must be dropped
    @(negedge clk);
    mem_valid = 1'b1; mem_op = 4'd1; mem_addr = 32'h0000_0020; mem_ovf = 1'b0;
    bus.bus_ack = 1'b0;
    #1;
    chk("req_issue_stall", 32'(mem_stall), 32'd1);
    @(negedge clk); #1;
    chk("req_w1_req", 32'(bus.bus_req), 32'd1);
    @(negedge clk);
    Req = 1'b1; bus.bus_ack = 1'b1; bus.bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    Req = 1'b0; bus.bus_ack = 1'b0; mem_valid = 1'b0;
    #1;
    chk("req_flush_req", 32'(bus.bus_req), 32'd0);
    chk("req_flush_stall", 32'(mem_stall), 32'd0);
    chk("req_flush_exc", 32'(mem_exc), 32'd0);
    chk("req_flush_rdata", mem_rdata, ref_rdata);
    @(negedge clk); #1;
    chk("req_idle_stall", 32'(mem_stall), 32'd0);
    chk("req_idle_rdata", mem_rdata, ref_rdata);

    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(1, 8));
      case ($urandom_range(0, 5))
        0: a = $urandom_range(0, 32'h2FFF);
        1: a = 32'h2FF8 + $urandom_range(0, 15);
        2: a = 32'h7F00 + $urandom_range(0, 15);
        3: a = 32'h7F10 + $urandom_range(0, 15);
        4: a = 32'h7F1C + $urandom_range(0, 11);
        default: a = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      ack = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
      access(op, a, ($urandom_range(0, 7) == 0), $urandom, ack, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
